// File: rtl/cpu_sram_arbiter_pkg.sv
// rtl/cpu_sram_arbiter_pkg.sv - shared encodings for the cpu sram-like port arbiter
package cpu_sram_arbiter_pkg;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } size_e;

   typedef enum logic {
      OWN_INST = 1'b0,
      OWN_DATA = 1'b1
   } owner_e;

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_INST = 2'd1,
      LOCK_DATA = 2'd2
   } lock_e;

   typedef struct packed {
      logic        req;
      logic        wr;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
   } mem_cmd_t;

   // Data normally wins; a starved inst requester takes the port once.
   function automatic logic pick_data(input logic inst_req, input logic data_req,
                                      input logic starve_hit);
      return data_req & ~(inst_req & starve_hit);
   endfunction

endpackage

// File: rtl/cpu_sram_arbiter_arb_owner_fifo.sv
// rtl/cpu_sram_arbiter_arb_owner_fifo.sv - 1-bit owner FIFO recording who issued each outstanding transaction
module arb_owner_fifo #(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_push,
   input  logic                    i_push_data,
   input  logic                    i_pop,
   output logic                    o_head,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [$clog2(DEPTH):0]  o_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [DEPTH-1:0] r_mem;
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   // Full blocks a push even when a pop happens in the same cycle.
   assign w_push = i_push & (r_count != FULL_CNT);
   assign w_pop  = i_pop & (r_count != '0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_mem   <= '0;
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
            r_wptr        <= r_wptr + 1'b1;
         end
         if (w_pop) begin
            r_rptr <= r_rptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_head  = r_mem[r_rptr];
   assign o_full  = (r_count == FULL_CNT);
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/cpu_sram_arbiter.sv
// rtl/cpu_sram_arbiter.sv - shares one sram-like port between inst fetch and data access
module cpu_sram_arbiter
   import cpu_sram_arbiter_pkg::*;
#(
   parameter int OUTSTANDING  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [1:0]  mem_size,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_addr_ok,
   input  logic        mem_data_ok,
   input  logic [31:0] mem_rdata
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam int CW = $clog2(OUTSTANDING) + 1;
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [CW-1:0] FIFO_DEPTH = CW'(OUTSTANDING);

   lock_e         r_lock;
   logic [SW-1:0] r_starve;

   mem_cmd_t      w_inst_cmd;
   mem_cmd_t      w_data_cmd;
   mem_cmd_t      w_mem_cmd;
   logic          w_sel_valid;
   logic          w_sel_data;
   logic          w_accept;
   logic          w_pop;
   logic          w_push_owner;
   logic          w_fifo_head;
   logic          w_fifo_full;
   logic          w_fifo_empty;
   logic [CW-1:0] w_fifo_count;

   assign w_inst_cmd = '{req: inst_req, wr: 1'b0, size: SIZE_W, addr: inst_addr, wdata: 32'd0};
   assign w_data_cmd = '{req: data_req, wr: data_wr, size: data_size, addr: data_addr,
                         wdata: data_wdata};

   // A locked requester keeps the port; otherwise arbitrate only when a slot is free.
   always_comb begin
      w_sel_valid = 1'b0;
      w_sel_data  = 1'b0;
      case (r_lock)
         LOCK_INST: w_sel_valid = 1'b1;
         LOCK_DATA: begin
            w_sel_valid = 1'b1;
            w_sel_data  = 1'b1;
         end
         default: begin
            if (!w_fifo_full && (inst_req || data_req)) begin
               w_sel_valid = 1'b1;
               w_sel_data  = pick_data(inst_req, data_req, r_starve == STARVE_MAX);
            end
         end
      endcase
   end

   always_comb begin
      w_mem_cmd = '0;
      if (w_sel_valid) begin
         w_mem_cmd = w_sel_data ? w_data_cmd : w_inst_cmd;
      end
   end

   assign mem_req   = w_mem_cmd.req;
   assign mem_wr    = w_mem_cmd.wr;
   assign mem_size  = w_mem_cmd.size;
   assign mem_addr  = w_mem_cmd.addr;
   assign mem_wdata = w_mem_cmd.wdata;

   assign w_accept     = mem_req & mem_addr_ok;
   assign inst_addr_ok = w_accept & ~w_sel_data;
   assign data_addr_ok = w_accept & w_sel_data;
   assign w_push_owner = w_sel_data ? OWN_DATA : OWN_INST;

   assign w_pop        = mem_data_ok & ~w_fifo_empty;
   assign inst_data_ok = w_pop & (w_fifo_head == OWN_INST);
   assign data_data_ok = w_pop & (w_fifo_head == OWN_DATA);
   assign inst_rdata   = mem_rdata;
   assign data_rdata   = mem_rdata;

   arb_owner_fifo #(
      .DEPTH (OUTSTANDING)
   ) u_owner_fifo (
      .clk         (clk),
      .reset       (reset),
      .i_push      (w_accept),
      .i_push_data (w_push_owner),
      .i_pop       (w_pop),
      .o_head      (w_fifo_head),
      .o_full      (w_fifo_full),
      .o_empty     (w_fifo_empty),
      .o_count     (w_fifo_count)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_lock   <= LOCK_NONE;
         r_starve <= '0;
      end else begin
         if (mem_req && !mem_addr_ok) begin
            r_lock <= w_sel_data ? LOCK_DATA : LOCK_INST;
         end else begin
            r_lock <= LOCK_NONE;
         end
         if (!inst_req || inst_addr_ok) begin
            r_starve <= '0;
         end else if (data_addr_ok && r_starve != STARVE_MAX) begin
            r_starve <= r_starve + 1'b1;
         end
      end
   end

   assert property (@(posedge clk) disable iff (reset) w_fifo_count <= FIFO_DEPTH);

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// tb/tb_cpu_sram_arbiter.sv - scoreboard bench for cpu_sram_arbiter
module tb_cpu_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        mem_req, mem_wr;
   logic [1:0]  mem_size;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_addr_ok, mem_data_ok;
   logic [31:0] mem_rdata;

   typedef struct packed { logic own; logic [31:0] val; } exp_t;
   typedef struct packed { logic wr; logic [1:0] size; logic [31:0] addr; logic [31:0] wdata; } dreq_t;

   exp_t        exp_grant[$];
   exp_t        exp_resp[$];
   logic [31:0] inst_q[$];
   dreq_t       data_q[$];
   logic [31:0] pend_q[$];
   int          n_cmp = 0;
   int          n_fail = 0;

   logic        aok_auto, man_aok, resp_auto, man_dok;
   logic [31:0] man_rdata;
   logic        auto_dok;
   logic [31:0] auto_rdata;

   assign mem_addr_ok = aok_auto | man_aok;
   assign mem_data_ok = resp_auto ? auto_dok : man_dok;
   assign mem_rdata   = resp_auto ? auto_rdata : man_rdata;

   always #5 clk = ~clk;

   cpu_sram_arbiter #(.OUTSTANDING(2), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
      .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
      .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
      .data_rdata(data_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
      .mem_rdata(mem_rdata)
   );

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endfunction

   function automatic void expect_txn(logic own, logic [31:0] addr, logic [31:0] rdata);
      exp_grant.push_back('{own: own, val: addr});
      exp_resp.push_back('{own: own, val: rdata});
   endfunction

   task automatic drv();
      @(posedge clk);
      #2;
   endtask

   initial begin : inst_master
      logic acc;
      inst_req  = 1'b0;
      inst_addr = 32'd0;
      forever begin
         @(negedge clk);
         acc = inst_req & inst_addr_ok;
         @(posedge clk);
         #1;
         if (acc) inst_req = 1'b0;
         if (!inst_req && inst_q.size() > 0) begin
            inst_addr = inst_q.pop_front();
            inst_req  = 1'b1;
         end
      end
   end

   initial begin : data_master
      logic  acc;
      dreq_t d;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_addr = 32'd0; data_wdata = 32'd0;
      forever begin
         @(negedge clk);
         acc = data_req & data_addr_ok;
         @(posedge clk);
         #1;
         if (acc) data_req = 1'b0;
         if (!data_req && data_q.size() > 0) begin
            d = data_q.pop_front();
            data_wr = d.wr; data_size = d.size; data_addr = d.addr; data_wdata = d.wdata;
            data_req = 1'b1;
         end
      end
   end

   // Downstream model: answers each accept one cycle later with ~address.
   initial begin : responder
      logic        acc;
      logic [31:0] a;
      auto_dok   = 1'b0;
      auto_rdata = 32'd0;
      forever begin
         @(negedge clk);
         acc = mem_req & mem_addr_ok;
         a   = mem_addr;
         @(posedge clk);
         #1;
         auto_dok   = 1'b0;
         auto_rdata = 32'd0;
         if (resp_auto && acc) pend_q.push_back(a);
         if (resp_auto && pend_q.size() > 0) begin
            auto_dok   = 1'b1;
            auto_rdata = ~pend_q.pop_front();
         end
      end
   end

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (inst_addr_ok || data_addr_ok) begin
            if (exp_grant.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL grant_unexpected: got owner %0d addr 0x%08h expected none", data_addr_ok, mem_addr);
            end else begin
               e = exp_grant.pop_front();
               chk("grant_owner", 32'(data_addr_ok), 32'(e.own));
               chk("grant_addr", mem_addr, e.val);
               chk("grant_onehot", 32'(inst_addr_ok & data_addr_ok), 32'd0);
            end
         end
         if (inst_data_ok || data_data_ok) begin
            if (exp_resp.size() == 0) begin
               n_cmp++; n_fail++;
               $display("FAIL resp_unexpected: got owner %0d rdata 0x%08h expected none", data_data_ok, mem_rdata);
            end else begin
               e = exp_resp.pop_front();
               chk("resp_owner", 32'(data_data_ok), 32'(e.own));
               chk("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.val);
               chk("resp_onehot", 32'(inst_data_ok & data_data_ok), 32'd0);
            end
         end
      end
   end

   initial begin : watchdog
      #50000;
      $display("FAIL watchdog: got no finish expected finish before 50000 ns");
      $fatal(1, "timeout");
   end

   initial begin : main
      reset = 1'b1; aok_auto = 1'b0; man_aok = 1'b0; resp_auto = 1'b0;
      man_dok = 1'b0; man_rdata = 32'd0;
      @(negedge clk);
      chk("rst_mem_req", 32'(mem_req), 32'd0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_fields", {29'd0, mem_wr, mem_size}, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_acks", {28'd0, inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 32'd0);
      drv();
      reset = 1'b0;
      drv();

      // Single inst read, addr_ok after 2 waits, data 3 cycles after accept.
      inst_q.push_back(32'hBFC00000);
      expect_txn(1'b0, 32'hBFC00000, 32'h3C080001);
      drv();
      for (int i = 0; i < 3; i++) begin
         man_aok = (i == 2);
         @(negedge clk);
         chk("t1_mem_req_held", 32'(mem_req), 32'd1);
         chk("t1_mem_addr_held", mem_addr, 32'hBFC00000);
         chk("t1_inst_size", 32'(mem_size), 32'd2);
         drv();
      end
      man_aok = 1'b0;
      @(negedge clk);
      chk("t1_req_released", 32'(mem_req), 32'd0);
      drv(); drv();
      man_dok = 1'b1; man_rdata = 32'h3C080001;
      drv();
      man_dok = 1'b0; man_rdata = 32'd0;

      // Simultaneous inst and data write: data first, then inst.
      aok_auto = 1'b1; resp_auto = 1'b1;
      inst_q.push_back(32'hBFC00004);
      data_q.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h80001000, wdata: 32'h12345678});
      expect_txn(1'b1, 32'h80001000, ~32'h80001000);
      expect_txn(1'b0, 32'hBFC00004, ~32'hBFC00004);
      drv();
      @(negedge clk);
      chk("t2_data_wr", 32'(mem_wr), 32'd1);
      chk("t2_data_wdata", mem_wdata, 32'h12345678);
      chk("t2_data_size", 32'(mem_size), 32'd2);
      drv();
      @(negedge clk);
      chk("t2_inst_wr_forced", 32'(mem_wr), 32'd0);
      chk("t2_inst_wdata_forced", mem_wdata, 32'd0);
      drv(); drv(); drv();

      // FIFO full blocks grant; a same-cycle pop does not free a slot.
      resp_auto = 1'b0;
      inst_q.push_back(32'hBFC00010);
      inst_q.push_back(32'hBFC00014);
      inst_q.push_back(32'hBFC00018);
      expect_txn(1'b0, 32'hBFC00010, 32'h11111111);
      expect_txn(1'b0, 32'hBFC00014, 32'h22222222);
      expect_txn(1'b0, 32'hBFC00018, 32'h33333333);
      drv(); drv(); drv();
      @(negedge clk);
      chk("t3_full_no_req", 32'(mem_req), 32'd0);
      drv();
      man_dok = 1'b1; man_rdata = 32'h11111111;
      @(negedge clk);
      chk("t3_pop_same_cycle_no_req", 32'(mem_req), 32'd0);
      drv();
      man_dok = 1'b0;
      @(negedge clk);
      chk("t3_regrant_after_pop", 32'(mem_req), 32'd1);
      drv();
      man_dok = 1'b1; man_rdata = 32'h22222222;
      drv();
      man_rdata = 32'h33333333;
      drv();
      man_dok = 1'b0; man_rdata = 32'd0;
      drv();

      // Continuous contention: D,D,D,D,I,D,D,D,D,I.
      resp_auto = 1'b1;
      for (int k = 0; k < 8; k++) begin
         data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80002000 + 32'(4*k), wdata: 32'd0});
      end
      inst_q.push_back(32'hBFC00400);
      inst_q.push_back(32'hBFC00404);
      for (int k = 0; k < 10; k++) begin
         if (k == 4)      expect_txn(1'b0, 32'hBFC00400, ~32'hBFC00400);
         else if (k == 9) expect_txn(1'b0, 32'hBFC00404, ~32'hBFC00404);
         else begin
            automatic logic [31:0] a = 32'h80002000 + 32'(4 * (k < 4 ? k : k - 1));
            expect_txn(1'b1, a, ~a);
         end
      end
      repeat (14) drv();

      // Lock on data while starve reaches its limit, then inst forced.
      aok_auto = 1'b0; man_aok = 1'b1;
      data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80003000, wdata: 32'd0});
      data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80003004, wdata: 32'd0});
      data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80003008, wdata: 32'd0});
      data_q.push_back('{wr: 1'b1, size: 2'd1, addr: 32'h8000300C, wdata: 32'h0000BEEF});
      data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80003010, wdata: 32'd0});
      inst_q.push_back(32'hBFC00500);
      expect_txn(1'b1, 32'h80003000, ~32'h80003000);
      expect_txn(1'b1, 32'h80003004, ~32'h80003004);
      expect_txn(1'b1, 32'h80003008, ~32'h80003008);
      expect_txn(1'b1, 32'h8000300C, ~32'h8000300C);
      expect_txn(1'b0, 32'hBFC00500, ~32'hBFC00500);
      expect_txn(1'b1, 32'h80003010, ~32'h80003010);
      drv(); drv(); drv(); drv();
      man_aok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_locked_data_addr", mem_addr, 32'h8000300C);
         chk("t5_locked_data_size", 32'(mem_size), 32'd1);
         chk("t5_locked_req", 32'(mem_req), 32'd1);
         drv();
      end
      man_aok = 1'b1;
      drv();
      @(negedge clk);
      chk("t5_starve_forces_inst", 32'(inst_addr_ok), 32'd1);
      drv(); drv(); drv();

      // Lock on inst: a later data request must not steal the port.
      man_aok = 1'b0;
      inst_q.push_back(32'hBFC00600);
      expect_txn(1'b0, 32'hBFC00600, ~32'hBFC00600);
      expect_txn(1'b1, 32'h80003020, ~32'h80003020);
      drv();
      data_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h80003020, wdata: 32'd0});
      drv();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t5_locked_inst_addr", mem_addr, 32'hBFC00600);
         chk("t5_locked_inst_wr", 32'(mem_wr), 32'd0);
         drv();
      end
      man_aok = 1'b1;
      drv(); drv(); drv(); drv();
      man_aok = 1'b0;

      // Reset with two outstanding; stray responses are dropped.
      aok_auto = 1'b1; resp_auto = 1'b0;
      inst_q.push_back(32'hBFC00700);
      inst_q.push_back(32'hBFC00704);
      exp_grant.push_back('{own: 1'b0, val: 32'hBFC00700});
      exp_grant.push_back('{own: 1'b0, val: 32'hBFC00704});
      drv(); drv(); drv();
      reset = 1'b1;
      @(negedge clk);
      chk("t6_rst_mem_req", 32'(mem_req), 32'd0);
      drv(); drv();
      reset = 1'b0;
      drv();
      for (int i = 0; i < 2; i++) begin
         man_dok = 1'b1; man_rdata = 32'hDEADBEEF;
         @(negedge clk);
         chk("t6_stray_inst_data_ok", 32'(inst_data_ok), 32'd0);
         chk("t6_stray_data_data_ok", 32'(data_data_ok), 32'd0);
         drv();
      end
      man_dok = 1'b0; man_rdata = 32'd0;
      inst_q.push_back(32'hBFC00800);
      expect_txn(1'b0, 32'hBFC00800, 32'hCAFEF00D);
      drv(); drv();
      man_dok = 1'b1; man_rdata = 32'hCAFEF00D;
      drv();
      man_dok = 1'b0; man_rdata = 32'd0;
      drv(); drv();

      chk("grants_drained", 32'(exp_grant.size()), 32'd0);
      chk("resps_drained", 32'(exp_resp.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
